ifetch_queue: RTL

- Instruction fetch/prefetch stage directly upstream of the instruction decoder.
- Issues 32-bit fetches to the instruction bus and splits each word into two 16-bit SH opcodes (big-endian: addr[1]=0 -> rdata[31:16]).
- Buffers the opcodes in a small queue and presents one opcode per cycle on op.
- Honours decoder stall/pc_hold and flushes on a PC redirect (branch, exception, PC load).

---
 rtl/ifetch_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches 32-bit words, splits them into two 16-bit
// opcodes (high halfword first) and presents one opcode per cycle to the decoder.
module ifetch_queue #(
  parameter int          DEPTH  = 4,
  parameter logic [15:0] RST_OP = 16'h0009
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [31:0]            flush_addr,
  input  logic                   stall,
  input  logic                   pc_hold,
  output logic [15:0]            op,
  output logic                   op_vld,
  output logic                   if_req,
  output logic [31:0]            if_addr,
  input  logic                   if_ack,
  input  logic [31:0]            if_rdata,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_e;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  // Fetch handshake: once if_req rises, if_req and if_addr hold until the cycle
  // with if_ack=1; if_rdata is captured in that same cycle. One request at a time.
  state_e      state_q, state_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic [29:0] drop_word_q, drop_word_d;
  logic        skip_hi_q, skip_hi_d;
  logic        pc_valid_q, pc_valid_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;
  logic [15:0] mem_q [DEPTH];

  logic        consume;
  logic        acked;
  logic        push_two;
  logic        push_one;
  cnt_t        push_n;
  logic        room_ok;
  logic        unused_addr_bit;

  assign unused_addr_bit = flush_addr[0];

  // Queue bookkeeping; a flush overrides any push or consume in the same cycle.
  always_comb begin
    consume  = (count_q != '0) & ~stall & ~pc_hold;
    acked    = if_ack & (state_q == REQ);
    push_two = acked & ~skip_hi_q & ~flush;
    push_one = acked & skip_hi_q & ~flush;
    push_n   = '0;
    if (push_two) begin
      push_n = cnt_t'(2);
    end else if (push_one) begin
      push_n = cnt_t'(1);
    end
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + push_n - cnt_t'(consume);
      rd_ptr_d = rd_ptr_q + ptr_t'(consume);
      wr_ptr_d = wr_ptr_q + ptr_t'(push_n);
    end
    room_ok = (int'(count_d) + 2) <= DEPTH;
  end

  always_comb begin
    state_d     = state_q;
    if_addr_d   = if_addr_q;
    drop_word_d = drop_word_q;
    skip_hi_d   = skip_hi_q;
    pc_valid_d  = pc_valid_q;
    if (flush) begin
      skip_hi_d  = flush_addr[1];
      pc_valid_d = 1'b1;
      // A request still in flight must complete before the new target is issued.
      if (state_q != IDLE && !if_ack) begin
        state_d     = DROP;
        drop_word_d = flush_addr[31:2];
      end else begin
        state_d   = REQ;
        if_addr_d = {flush_addr[31:2], 2'b00};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_valid_q && room_ok) state_d = REQ;
        end
        REQ: begin
          if (if_ack) begin
            if_addr_d = if_addr_q + 32'd4;
            skip_hi_d = 1'b0;
            state_d   = room_ok ? REQ : IDLE;
          end
        end
        DROP: begin
          if (if_ack) begin
            if_addr_d = {drop_word_q, 2'b00};
            state_d   = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      if_addr_q   <= '0;
      drop_word_q <= '0;
      skip_hi_q   <= 1'b0;
      pc_valid_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      if_addr_q   <= if_addr_d;
      drop_word_q <= drop_word_d;
      skip_hi_q   <= skip_hi_d;
      pc_valid_q  <= pc_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_two) begin
      mem_q[wr_ptr_q]            <= if_rdata[31:16];
      mem_q[wr_ptr_q + ptr_t'(1)] <= if_rdata[15:0];
    end else if (push_one) begin
      mem_q[wr_ptr_q] <= if_rdata[15:0];
    end
  end

  always_comb begin
    op_vld    = (count_q != '0);
    op        = op_vld ? mem_q[rd_ptr_q] : RST_OP;
    if_req    = (state_q != IDLE);
    if_addr   = if_addr_q;
    dbg_state = state_q;
    dbg_count = count_q;
  end

  // The issue rule guarantees room for every acked word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (acked && !flush) |-> (int'(count_q) + int'(push_n) - int'(consume) <= DEPTH));

endmodule
